// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cycles_f(input int width, input int slice);
        return width / slice;
    endfunction

    // Counter stays at least one bit wide even for single-cycle configurations.
    function automatic int cnt_w_f(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder over SLICE bits.
module adder_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co = carry[SLICE];
    end

endmodule

// File: rtl/multi_cycle_adder.sv
// Sequential adder: WIDTH-bit a+b+cin computed SLICE bits per clock with valid/ready in and out.
// Optional self-check output check_err is enabled by defining ADDER_SELF_CHECK_EN.
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef ADDER_SELF_CHECK_EN
    ,
    output logic             check_err
`endif
);

    localparam int CYCLES = cycles_f(WIDTH, SLICE);
    localparam int CNT_W  = cnt_w_f(CYCLES);

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_err
        $error("multi_cycle_adder: SLICE must be >=1 and divide WIDTH exactly");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SLICE-1:0]       slice_s;
    logic                   slice_co;
    logic [WIDTH+SLICE-1:0] sum_shift;
    logic                   accept;
    logic                   last_slice;

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a   (a_q[SLICE-1:0]),
        .b   (b_q[SLICE-1:0]),
        .cin (carry_q),
        .s   (slice_s),
        .co  (slice_co)
    );

    // New slice enters at the MSB end so the finished sum lands LSB-aligned.
    assign sum_shift  = {slice_s, sum_q} >> SLICE;
    assign accept     = in_valid & in_ready;
    assign last_slice = (cnt_q == CNT_W'(CYCLES - 1));

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) | (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                sum_d   = sum_shift[WIDTH-1:0];
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    cout_d  = slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ADDER_SELF_CHECK_EN
    logic [WIDTH-1:0] ref_a_q, ref_a_d;
    logic [WIDTH-1:0] ref_b_q, ref_b_d;
    logic             ref_cin_q, ref_cin_d;
    logic [WIDTH:0]   ref_sum;

    always_comb begin
        ref_a_d   = ref_a_q;
        ref_b_d   = ref_b_q;
        ref_cin_d = ref_cin_q;
        if (accept) begin
            ref_a_d   = a;
            ref_b_d   = b;
            ref_cin_d = cin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_a_q   <= '0;
            ref_b_q   <= '0;
            ref_cin_q <= 1'b0;
        end else begin
            ref_a_q   <= ref_a_d;
            ref_b_q   <= ref_b_d;
            ref_cin_q <= ref_cin_d;
        end
    end

    assign ref_sum   = {1'b0, ref_a_q} + {1'b0, ref_b_q} + {{WIDTH{1'b0}}, ref_cin_q};
    assign check_err = (state_q == DONE) && (ref_sum != {cout_q, sum_q});
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed and random self-checking bench for multi_cycle_adder (SLICE=1, 4 and 8 instances).
module tb_multi_cycle_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       check_err;

    logic       w_in_valid;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_cin;
    logic       w_out_ready;
    logic       in_ready4, out_valid4, cout4, busy4, check_err4;
    logic       in_ready8, out_valid8, cout8, busy8, check_err8;
    logic [7:0] sum4, sum8;

    int checks   = 0;
    int failures = 0;

    multi_cycle_adder #(.WIDTH(8), .SLICE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef ADDER_SELF_CHECK_EN
        ,
        .check_err (check_err)
`endif
    );

    multi_cycle_adder #(.WIDTH(8), .SLICE(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (in_ready4),
        .a         (w_a),
        .b         (w_b),
        .cin       (w_cin),
        .out_valid (out_valid4),
        .out_ready (w_out_ready),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
`ifdef ADDER_SELF_CHECK_EN
        ,
        .check_err (check_err4)
`endif
    );

    multi_cycle_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (in_ready8),
        .a         (w_a),
        .b         (w_b),
        .cin       (w_cin),
        .out_valid (out_valid8),
        .out_ready (w_out_ready),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
`ifdef ADDER_SELF_CHECK_EN
        ,
        .check_err (check_err8)
`endif
    );

`ifndef ADDER_SELF_CHECK_EN
    assign check_err  = 1'b0;
    assign check_err4 = 1'b0;
    assign check_err8 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and wait (bounded) for the accept edge; leaves time at accept edge + 1.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int n;
        @(negedge clk);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        cin      = 'x;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (lat < 40) begin
            lat++;
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic collectResult(input string tag, input logic [7:0] exp_sum, input logic exp_cout,
                                 input int stall);
        repeat (stall) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        checkOutput({tag, "_chk"}, 32'(check_err), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int         lat, lat4, lat8;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp9;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
        w_a         = '0;
        w_b         = '0;
        w_cin       = 1'b0;

        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // 0xFF + 0x01 wraps to zero with carry out
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_in_ready", 32'(in_ready), 32'd0);
        waitValid(lat);
        checkOutput("t1_latency", 32'(lat), 32'd8);
        collectResult("t1", 8'h00, 1'b1, 0);
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);
        checkOutput("t1_held_sum", 32'(sum), 32'h00);
        checkOutput("t1_held_cout", 32'(cout), 32'd1);

        applyStimulus(8'h5A, 8'hA5, 1'b1);
        waitValid(lat);
        checkOutput("t2a_latency", 32'(lat), 32'd8);
        collectResult("t2a", 8'h00, 1'b1, 0);

        applyStimulus(8'h12, 8'h34, 1'b0);
        waitValid(lat);
        collectResult("t2b", 8'h46, 1'b0, 0);

        // Backpressure: 0x80+0x80+1 = 0x101, new operands pending throughout
        applyStimulus(8'h80, 8'h80, 1'b1);
        waitValid(lat);
        checkOutput("bp_latency", 32'(lat), 32'd8);
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        cin      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_sum", 32'(sum), 32'h01);
            checkOutput("bp_cout", 32'(cout), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_drop", 32'(out_valid), 32'd0);
        checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_busy", 32'(busy), 32'd0);
        checkOutput("bp_idle_sum", 32'(sum), 32'h01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_accept_busy", 32'(busy), 32'd1);
        waitValid(lat);
        checkOutput("bp2_latency", 32'(lat), 32'd8);
        collectResult("bp2", 8'h33, 1'b0, 0);

        // Asynchronous reset three cycles into an operation
        applyStimulus(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ra_valid", 32'(out_valid), 32'd0);
        checkOutput("ra_sum", 32'(sum), 32'd0);
        checkOutput("ra_cout", 32'(cout), 32'd0);
        checkOutput("ra_busy", 32'(busy), 32'd0);
        checkOutput("ra_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h01, 8'h01, 1'b0);
        waitValid(lat);
        checkOutput("ra_next_latency", 32'(lat), 32'd8);
        collectResult("ra_next", 8'h02, 1'b0, 0);

        // Wide slices: 0x9C + 0x77 + 1 = 0x114
        @(negedge clk);
        checkOutput("w4_ready", 32'(in_ready4), 32'd1);
        checkOutput("w8_ready", 32'(in_ready8), 32'd1);
        w_a        = 8'h9C;
        w_b        = 8'h77;
        w_cin      = 1'b1;
        w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat4 = 0;
        lat8 = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (out_valid4 && lat4 == 0) lat4 = e;
            if (out_valid8 && lat8 == 0) lat8 = e;
        end
        checkOutput("w4_latency", 32'(lat4), 32'd2);
        checkOutput("w8_latency", 32'(lat8), 32'd1);
        checkOutput("w4_sum", 32'(sum4), 32'h14);
        checkOutput("w4_cout", 32'(cout4), 32'd1);
        checkOutput("w8_sum", 32'(sum8), 32'h14);
        checkOutput("w8_cout", 32'(cout8), 32'd1);
        checkOutput("w4_chk", 32'(check_err4), 32'd0);
        checkOutput("w8_chk", 32'(check_err8), 32'd0);
        @(negedge clk);
        w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_out_ready = 1'b0;
        checkOutput("w4_drop", 32'(out_valid4), 32'd0);
        checkOutput("w8_drop", 32'(out_valid8), 32'd0);

        // Random operands with random consumer stalls
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            applyStimulus(ra, rb, rc);
            waitValid(lat);
            checkOutput("rnd_latency", 32'(lat), 32'd8);
            collectResult("rnd", exp9[7:0], exp9[8], int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
